// File: rtl/tl_txn_monitor_pkg.sv
// Shared types for the TileLink transaction monitor: opcodes, error indices,
// the per-source tracking entry and small decode helpers.
package tl_txn_monitor_pkg;

  typedef enum logic [2:0] {
    PutFullData    = 3'd0,
    PutPartialData = 3'd1,
    ArithmeticData = 3'd2,
    LogicalData    = 3'd3,
    Get            = 3'd4,
    Intent         = 3'd5
  } tl_a_op_e;

  typedef enum logic [2:0] {
    AccessAck     = 3'd0,
    AccessAckData = 3'd1,
    HintAck       = 3'd2
  } tl_d_op_e;

  typedef enum logic [3:0] {
    A_SRC_INUSE      = 4'd0,
    D_NO_REQ         = 4'd1,
    D_OPCODE         = 4'd2,
    D_SIZE           = 4'd3,
    A_BURST_MISMATCH = 4'd4,
    D_BURST_MISMATCH = 4'd5,
    A_MISALIGNED     = 4'd6,
    TIMEOUT          = 4'd7,
    A_ILLEGAL_OP     = 4'd8
  } tl_mon_err_e;

  localparam int unsigned NumMonErr = 9;
  localparam int unsigned MonSizeW  = 8;
  localparam int unsigned MonAgeW   = 16;

  // opcode is kept raw so an illegal request still occupies its entry.
  typedef struct packed {
    logic                valid;
    logic [2:0]          opcode;
    logic [MonSizeW-1:0] size;
    logic [MonAgeW-1:0]  age;
  } tl_mon_entry_t;

  function automatic logic a_op_has_data(input logic [2:0] op);
    return (op <= 3'd3);
  endfunction

  function automatic logic d_op_has_data(input logic [2:0] op);
    return (op == AccessAckData);
  endfunction

  function automatic logic [2:0] exp_d_opcode(input logic [2:0] a_op);
    logic [2:0] r;
    case (a_op)
      Get, ArithmeticData, LogicalData: r = AccessAckData;
      Intent:                           r = HintAck;
      default:                          r = AccessAck;
    endcase
    return r;
  endfunction

  function automatic int unsigned beat_count(input int unsigned size,
                                             input logic has_data,
                                             input int unsigned beat_log);
    if (has_data && size > beat_log) return 32'd1 << (size - beat_log);
    return 32'd1;
  endfunction

endpackage

// File: rtl/tl_txn_monitor_if.sv
// A and D channel taps of one TileLink link, as seen by a passive monitor.
// A beat transfers on a rising clk edge where valid and ready are both high;
// valid/ready are owned by the link agents, the monitor only observes them.
interface tl_txn_monitor_if #(
  parameter int unsigned AddrWidth   = 56,
  parameter int unsigned SourceWidth = 4,
  parameter int unsigned SizeWidth   = 3
);
  logic                   a_valid;
  logic                   a_ready;
  logic [2:0]             a_opcode;
  logic [SizeWidth-1:0]   a_size;
  logic [SourceWidth-1:0] a_source;
  logic [AddrWidth-1:0]   a_address;
  logic                   d_valid;
  logic                   d_ready;
  logic [2:0]             d_opcode;
  logic [SizeWidth-1:0]   d_size;
  logic [SourceWidth-1:0] d_source;

  modport master (
    output a_valid, a_ready, a_opcode, a_size, a_source, a_address,
    output d_valid, d_ready, d_opcode, d_size, d_source
  );

  modport slave (
    input a_valid, a_ready, a_opcode, a_size, a_source, a_address,
    input d_valid, d_ready, d_opcode, d_size, d_source
  );
endinterface

// File: rtl/tl_txn_monitor_beat_tracker.sv
// Frames multi-beat messages on one channel: flags first/last beat and holds
// the first beat's header so later beats can be compared against it.
module tl_txn_monitor_beat_tracker
  import tl_txn_monitor_pkg::*;
#(
  parameter int unsigned SizeWidth   = 3,
  parameter int unsigned SourceWidth = 4,
  parameter int unsigned AddrWidth   = 56,
  parameter int unsigned BeatLog     = 3
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   fire,
  input  logic                   has_data,
  input  logic [2:0]             opcode,
  input  logic [SizeWidth-1:0]   size,
  input  logic [SourceWidth-1:0] source,
  input  logic [AddrWidth-1:0]   address,
  output logic                   first,
  output logic                   last,
  output logic [2:0]             first_opcode,
  output logic [SizeWidth-1:0]   first_size,
  output logic [SourceWidth-1:0] first_source,
  output logic [AddrWidth-1:0]   first_address
);
  localparam int unsigned CntW = 2**SizeWidth;

  logic [CntW-1:0] cnt_q;
  logic            first_has_data_q;
  int unsigned     len;

  // Later beats are framed by the first beat's size so a corrupted size
  // on a middle beat cannot shift the message boundary.
  always_comb begin
    first = (cnt_q == '0);
    len   = first ? beat_count(32'(size), has_data, BeatLog)
                  : beat_count(32'(first_size), first_has_data_q, BeatLog);
    last  = (cnt_q == CntW'(len - 32'd1));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q            <= '0;
      first_has_data_q <= 1'b0;
      first_opcode     <= '0;
      first_size       <= '0;
      first_source     <= '0;
      first_address    <= '0;
    end else if (fire) begin
      if (first) begin
        first_has_data_q <= has_data;
        first_opcode     <= opcode;
        first_size       <= size;
        first_source     <= source;
        first_address    <= address;
      end
      cnt_q <= last ? '0 : cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/tl_txn_monitor.sv
// Passive TL-UL/TL-UH monitor: tracks outstanding requests per source and
// reports protocol violations as sticky flags, a pulse and a saturating count.
module tl_txn_monitor
  import tl_txn_monitor_pkg::*;
#(
  parameter int unsigned DataWidth     = 64,
  parameter int unsigned AddrWidth     = 56,
  parameter int unsigned SourceWidth   = 4,
  parameter int unsigned SizeWidth     = 3,
  parameter int unsigned TimeoutCycles = 1024,
  parameter int unsigned ErrCntWidth   = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  tl_txn_monitor_if.slave        tl,
  output logic [NumMonErr-1:0]   err_o,
  output logic                   err_pulse_o,
  output logic [ErrCntWidth-1:0] err_cnt_o,
  output logic [SourceWidth:0]   outstanding_o,
  output logic                   idle_o
);
  localparam int unsigned BeatLog = $clog2(DataWidth / 8);
  localparam int unsigned Depth   = 2**SourceWidth;
  localparam logic [MonAgeW-1:0] AgeLimit = MonAgeW'(TimeoutCycles);

  tl_mon_entry_t tbl_q [Depth];
  tl_mon_entry_t tbl_d [Depth];
  tl_mon_entry_t d_ent;

  logic [NumMonErr-1:0]   err_q, new_err;
  logic                   pulse_q, tmo_evt_q;
  logic [ErrCntWidth-1:0] cnt_q;
  logic [SourceWidth:0]   outstanding_q;
  logic [Depth-1:0]       tmo_hit;
  logic                   a_fire, d_fire, a_data, d_data;
  logic                   alloc_new, free_en;
  logic [SourceWidth-1:0] d_src;
  logic [AddrWidth-1:0]   a_mask;

  logic                   a_first, a_last_unused, d_first, d_last;
  logic [2:0]             a_first_opcode, d_first_opcode;
  logic [SizeWidth-1:0]   a_first_size, d_first_size;
  logic [SourceWidth-1:0] a_first_source, d_first_source;
  logic [AddrWidth-1:0]   a_first_address;
  logic                   d_first_addr_unused;

  assign a_fire = tl.a_valid & tl.a_ready;
  assign d_fire = tl.d_valid & tl.d_ready;
  assign a_data = a_op_has_data(tl.a_opcode);
  assign d_data = d_op_has_data(tl.d_opcode);

  tl_txn_monitor_beat_tracker #(
    .SizeWidth(SizeWidth), .SourceWidth(SourceWidth),
    .AddrWidth(AddrWidth), .BeatLog(BeatLog)
  ) u_a_trk (
    .clk_i, .rst_i, .fire(a_fire), .has_data(a_data),
    .opcode(tl.a_opcode), .size(tl.a_size), .source(tl.a_source),
    .address(tl.a_address), .first(a_first), .last(a_last_unused),
    .first_opcode(a_first_opcode), .first_size(a_first_size),
    .first_source(a_first_source), .first_address(a_first_address)
  );

  tl_txn_monitor_beat_tracker #(
    .SizeWidth(SizeWidth), .SourceWidth(SourceWidth),
    .AddrWidth(1), .BeatLog(BeatLog)
  ) u_d_trk (
    .clk_i, .rst_i, .fire(d_fire), .has_data(d_data),
    .opcode(tl.d_opcode), .size(tl.d_size), .source(tl.d_source),
    .address(1'b0), .first(d_first), .last(d_last),
    .first_opcode(d_first_opcode), .first_size(d_first_size),
    .first_source(d_first_source), .first_address(d_first_addr_unused)
  );

  // Order within a cycle: age, then D free, then A allocate, so a
  // same-source free/allocate pair never looks like a source collision.
  always_comb begin
    tbl_d     = tbl_q;
    new_err   = '0;
    tmo_hit   = '0;
    alloc_new = 1'b0;
    free_en   = 1'b0;
    a_mask    = (AddrWidth'(1) << tl.a_size) - AddrWidth'(1);
    d_src     = d_first ? tl.d_source : d_first_source;
    d_ent     = tbl_q[d_src];

    for (int i = 0; i < Depth; i++) begin
      if (TimeoutCycles != 0 && tbl_q[i].valid && tbl_q[i].age != AgeLimit)
        tbl_d[i].age = tbl_q[i].age + 1'b1;
    end

    if (d_fire) begin
      if (d_first) begin
        if (!d_ent.valid) begin
          new_err[D_NO_REQ] = 1'b1;
        end else begin
          if (tl.d_opcode != exp_d_opcode(d_ent.opcode)) new_err[D_OPCODE] = 1'b1;
          if (MonSizeW'(tl.d_size) != d_ent.size)         new_err[D_SIZE]   = 1'b1;
        end
      end else if (tl.d_opcode != d_first_opcode || tl.d_size != d_first_size ||
                   tl.d_source != d_first_source) begin
        new_err[D_BURST_MISMATCH] = 1'b1;
      end
      if (d_last && d_ent.valid) begin
        free_en            = 1'b1;
        tbl_d[d_src].valid = 1'b0;
      end
    end

    if (a_fire) begin
      if (a_first) begin
        if (tl.a_opcode > 3'd5)               new_err[A_ILLEGAL_OP] = 1'b1;
        if ((tl.a_address & a_mask) != '0)    new_err[A_MISALIGNED] = 1'b1;
        if (tbl_d[tl.a_source].valid)         new_err[A_SRC_INUSE]  = 1'b1;
        else                                  alloc_new             = 1'b1;
        tbl_d[tl.a_source] = '{valid: 1'b1, opcode: tl.a_opcode,
                               size: MonSizeW'(tl.a_size), age: '0};
      end else if (tl.a_opcode != a_first_opcode || tl.a_size != a_first_size ||
                   tl.a_source != a_first_source || tl.a_address != a_first_address) begin
        new_err[A_BURST_MISMATCH] = 1'b1;
      end
    end

    for (int i = 0; i < Depth; i++) begin
      tmo_hit[i] = (TimeoutCycles != 0) && tbl_d[i].valid &&
                   tbl_d[i].age == AgeLimit && tbl_q[i].age != AgeLimit;
    end

    // The age reaching its limit is itself a registered event, reported a cycle later.
    new_err[TIMEOUT] = tmo_evt_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tbl_q         <= '{default: '0};
      err_q         <= '0;
      pulse_q       <= 1'b0;
      tmo_evt_q     <= 1'b0;
      cnt_q         <= '0;
      outstanding_q <= '0;
    end else begin
      tbl_q         <= tbl_d;
      err_q         <= err_q | new_err;
      pulse_q       <= |new_err;
      tmo_evt_q     <= |tmo_hit;
      if (|new_err && cnt_q != '1) cnt_q <= cnt_q + 1'b1;
      outstanding_q <= outstanding_q + (SourceWidth + 1)'(alloc_new)
                                     - (SourceWidth + 1)'(free_en);
    end
  end

  assign err_o         = err_q;
  assign err_pulse_o   = pulse_q;
  assign err_cnt_o     = cnt_q;
  assign outstanding_o = outstanding_q;
  assign idle_o        = (outstanding_q == '0) && a_first && d_first;

endmodule

// File: tb/tb_tl_txn_monitor.sv
// Directed bench for tl_txn_monitor: drivers push expected output snapshots,
// a negedge monitor pops and compares them against the DUT.
module tb_tl_txn_monitor;
  localparam int unsigned AW = 56;
  localparam int unsigned SW = 4;
  localparam int unsigned ZW = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [8:0]  err;
  logic        err_pulse;
  logic [15:0] err_cnt;
  logic [4:0]  outstanding;
  logic        idle;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];
  string       name_q[$];
  logic [31:0] mon_e, mon_a;
  string       mon_nm;

  tl_txn_monitor_if #(.AddrWidth(AW), .SourceWidth(SW), .SizeWidth(ZW)) tl ();

  tl_txn_monitor #(
    .DataWidth(64), .AddrWidth(AW), .SourceWidth(SW), .SizeWidth(ZW),
    .TimeoutCycles(8), .ErrCntWidth(16)
  ) dut (
    .clk_i(clk), .rst_i(rst), .tl(tl),
    .err_o(err), .err_pulse_o(err_pulse), .err_cnt_o(err_cnt),
    .outstanding_o(outstanding), .idle_o(idle)
  );

  // clock / reset
  always #5 clk = ~clk;

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_bus();
    tl.a_valid = 1'b0; tl.a_ready = 1'b1; tl.a_opcode = '0; tl.a_size = '0;
    tl.a_source = '0; tl.a_address = '0;
    tl.d_valid = 1'b0; tl.d_ready = 1'b1; tl.d_opcode = '0; tl.d_size = '0;
    tl.d_source = '0;
  endtask

  task automatic drive_a(input logic [2:0] op, input logic [2:0] sz,
                         input logic [3:0] src, input logic [55:0] addr);
    tl.a_valid = 1'b1; tl.a_ready = 1'b1; tl.a_opcode = op; tl.a_size = sz;
    tl.a_source = src; tl.a_address = addr;
  endtask

  task automatic drive_d(input logic [2:0] op, input logic [2:0] sz, input logic [3:0] src);
    tl.a_valid = 1'b0;
    tl.d_valid = 1'b1; tl.d_ready = 1'b1; tl.d_opcode = op; tl.d_size = sz;
    tl.d_source = src;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_bus();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic expect_obs(input string nm, input logic [8:0] e_err, input logic e_pulse,
                            input logic [15:0] e_cnt, input logic [4:0] e_out,
                            input logic e_idle);
    exp_q.push_back({e_err, e_pulse, e_cnt, e_out, e_idle});
    name_q.push_back(nm);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e  = exp_q.pop_front();
      mon_nm = name_q.pop_front();
      mon_a  = {err, err_pulse, err_cnt, outstanding, idle};
      checks++;
      if (mon_a !== mon_e) begin
        errors++;
        $display("FAIL %s: got err=%h pulse=%b cnt=%0d outst=%0d idle=%b, expected err=%h pulse=%b cnt=%0d outst=%0d idle=%b",
                 mon_nm, mon_a[31:23], mon_a[22], mon_a[21:6], mon_a[5:1], mon_a[0],
                 mon_e[31:23], mon_e[22], mon_e[21:6], mon_e[5:1], mon_e[0]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  // stimulus
  initial begin
    clear_bus();

    do_reset();
    expect_obs("reset_state", 9'h000, 0, 0, 0, 1);

    // Get src3 size3 -> AccessAckData, stalled one cycle by a_ready low
    drive_a(3'd4, 3'd3, 4'd3, 56'h18);
    tl.a_ready = 1'b0;
    tick(); expect_obs("s1_no_ready", 9'h000, 0, 0, 0, 1);
    tl.a_ready = 1'b1;
    tick(); expect_obs("s1_a_alloc", 9'h000, 0, 0, 1, 0);
    drive_d(3'd1, 3'd3, 4'd3);
    tick(); expect_obs("s1_d_free", 9'h000, 0, 0, 0, 1);
    clear_bus();

    // PutFull src1 size6, 8 beats, opcode changed on beat 4
    do_reset();
    drive_a(3'd0, 3'd6, 4'd1, 56'h40);
    tick(); expect_obs("s2_beat1", 9'h000, 0, 0, 1, 0);
    for (int b = 2; b <= 8; b++) begin
      drive_a((b == 4) ? 3'd1 : 3'd0, 3'd6, 4'd1, 56'h40);
      tick();
      if (b < 4)       expect_obs("s2_beat_clean", 9'h000, 0, 0, 1, 0);
      else if (b == 4) expect_obs("s2_beat4_mismatch", 9'h010, 1, 1, 1, 0);
      else             expect_obs("s2_beat_after", 9'h010, 0, 1, 1, 0);
    end
    drive_d(3'd0, 3'd6, 4'd1);
    tick(); expect_obs("s2_d_ack", 9'h010, 0, 1, 0, 1);
    clear_bus();

    // Get src2 answered with AccessAck, then D to idle src5
    do_reset();
    drive_a(3'd4, 3'd2, 4'd2, 56'h4);
    tick(); expect_obs("s3_a", 9'h000, 0, 0, 1, 0);
    drive_d(3'd0, 3'd2, 4'd2);
    tick(); expect_obs("s3_d_opcode", 9'h004, 1, 1, 0, 1);
    drive_d(3'd0, 3'd0, 4'd5);
    tick(); expect_obs("s3_d_no_req", 9'h006, 1, 2, 0, 1);
    clear_bus();

    // Source reuse before and on the D-last cycle
    do_reset();
    drive_a(3'd4, 3'd3, 4'd0, 56'h0);
    tick(); expect_obs("s4_a1", 9'h000, 0, 0, 1, 0);
    drive_a(3'd4, 3'd3, 4'd0, 56'h0);
    tick(); expect_obs("s4_src_inuse", 9'h001, 1, 1, 1, 0);
    drive_d(3'd1, 3'd3, 4'd0);
    drive_a(3'd4, 3'd3, 4'd0, 56'h0);
    tick(); expect_obs("s4_free_alloc", 9'h001, 0, 1, 1, 0);
    clear_bus();
    drive_d(3'd1, 3'd3, 4'd0);
    tick(); expect_obs("s4_final_free", 9'h001, 0, 1, 0, 1);
    clear_bus();

    // Timeout after 8 cycles, then a misaligned request
    do_reset();
    drive_a(3'd4, 3'd3, 4'd7, 56'h8);
    tick(); expect_obs("s5_a", 9'h000, 0, 0, 1, 0);
    clear_bus();
    repeat (8) tick();
    expect_obs("s5_before_timeout", 9'h000, 0, 0, 1, 0);
    tick(); expect_obs("s5_timeout", 9'h080, 1, 1, 1, 0);
    tick(); expect_obs("s5_timeout_once", 9'h080, 0, 1, 1, 0);
    drive_a(3'd4, 3'd3, 4'd8, 56'h4);
    tick(); expect_obs("s5_misaligned", 9'h0C0, 1, 2, 2, 0);
    clear_bus();

    // Reset in the middle of an 8-beat D burst
    do_reset();
    drive_a(3'd4, 3'd6, 4'd4, 56'h80);
    tick(); expect_obs("s6_a", 9'h000, 0, 0, 1, 0);
    drive_d(3'd1, 3'd6, 4'd4);
    tick(); expect_obs("s6_d_beat1", 9'h000, 0, 0, 1, 0);
    tick();
    tick(); expect_obs("s6_d_beat3", 9'h000, 0, 0, 1, 0);
    rst = 1'b1;
    tick(); expect_obs("s6_mid_reset", 9'h000, 0, 0, 0, 1);
    rst = 1'b0;
    drive_a(3'd4, 3'd3, 4'd4, 56'h100);
    tl.d_valid = 1'b0;
    tick(); expect_obs("s6_fresh_a", 9'h000, 0, 0, 1, 0);
    drive_d(3'd1, 3'd3, 4'd4);
    tick(); expect_obs("s6_fresh_d", 9'h000, 0, 0, 0, 1);
    clear_bus();

    // Response size mismatch, then an illegal opcode
    do_reset();
    drive_a(3'd4, 3'd2, 4'd6, 56'h10);
    tick(); expect_obs("s7_a", 9'h000, 0, 0, 1, 0);
    drive_d(3'd1, 3'd3, 4'd6);
    tick(); expect_obs("s7_d_size", 9'h008, 1, 1, 0, 1);
    tl.d_valid = 1'b0;
    drive_a(3'd6, 3'd0, 4'd9, 56'h3);
    tick(); expect_obs("s7_illegal_op", 9'h108, 1, 2, 1, 0);
    clear_bus();

    tick();
    tick();
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
